// File: rtl/dcache_wb_param_if.sv
// Block-wide memory handshake between the data cache and data memory.
// The cache drives the master side; the memory drives the slave side.
interface dcache_wb_param_if #(
    parameter int MADDR_W = 7,
    parameter int BLK_W   = 16
) ();
    logic               mem_read;
    logic               mem_write;
    logic [MADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]   mem_wdata;
    logic [BLK_W-1:0]   mem_rdata;
    logic               mem_ack;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/dcache_wb_param.sv
// Direct-mapped write-back write-allocate data cache with a
// req/ack block memory port and saturating hit/miss counters.
module dcache_wb_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LINES  = 8,
    parameter int WPB    = 2,
    parameter int CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                busy,
    dcache_wb_param_if.master   mem,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);
    localparam int OFF_W   = $clog2(WPB);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W   = DATA_W * WPB;
    localparam int MADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLK_W-1:0]   data_q [LINES];

    // Block address of the missing access, held across WRITEBACK/ALLOCATE.
    logic [MADDR_W-1:0] lat_blk;
    logic               retry_q;

    logic [OFF_W-1:0]   cur_off;
    logic [IDX_W-1:0]   cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic [BLK_W-1:0]   cur_blk;

    logic req;
    logic hit;
    logic do_hit;
    logic do_miss;
    logic wr_hit;
    logic fill;
    logic wb_done;

    assign cur_off = cpu_addr[OFF_W-1:0];
    assign cur_idx = cpu_addr[OFF_W +: IDX_W];
    assign cur_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign lat_idx = lat_blk[IDX_W-1:0];
    assign lat_tag = lat_blk[MADDR_W-1 -: TAG_W];
    assign cur_blk = data_q[cur_idx];

    assign req = cpu_read ^ cpu_write;
    assign hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    // Next state, CPU stall/data and memory handshake outputs.
    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        cpu_rdata     = '0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_addr  = lat_blk;
        mem.mem_wdata = data_q[lat_idx];
        do_hit        = 1'b0;
        do_miss       = 1'b0;
        wr_hit        = 1'b0;
        fill          = 1'b0;
        wb_done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    do_hit = 1'b1;
                    wr_hit = cpu_write;
                    if (cpu_read) begin
                        cpu_rdata = cur_blk[int'(cur_off)*DATA_W +: DATA_W];
                    end
                end else if (req) begin
                    busy    = 1'b1;
                    do_miss = 1'b1;
                    if (valid_q[cur_idx] && dirty_q[cur_idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                busy          = 1'b1;
                mem.mem_write = 1'b1;
                mem.mem_addr  = {tag_q[lat_idx], lat_idx};
                if (mem.mem_ack) begin
                    wb_done = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                busy         = 1'b1;
                mem.mem_read = 1'b1;
                if (mem.mem_ack) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, latched miss address, line status, counters.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_blk    <= '0;
            retry_q    <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= fill;
            if (do_miss) begin
                lat_blk <= cpu_addr[ADDR_W-1:OFF_W];
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
            if (do_hit && !retry_q && hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            if (wb_done) begin
                dirty_q[lat_idx] <= 1'b0;
            end
            if (fill) begin
                valid_q[lat_idx] <= 1'b1;
                dirty_q[lat_idx] <= 1'b0;
            end
            if (wr_hit) begin
                dirty_q[cur_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents survive reset, validity does not.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[lat_idx] <= mem.mem_rdata;
            tag_q[lat_idx]  <= lat_tag;
        end else if (wr_hit) begin
            data_q[cur_idx][int'(cur_off)*DATA_W +: DATA_W] <= cpu_wdata;
        end
    end
endmodule

// File: tb/tb_dcache_wb_param.sv
// Bench for dcache_wb_param: random traffic against a flat-memory
// model, directed scenarios, and a second wider configuration.
`timescale 1ns/1ps
module tb_dcache_wb_param;
    logic CLK = 1'b0;
    logic reset;

    always #5 CLK = ~CLK;

    logic        a_rd, a_wr;
    logic [7:0]  a_addr, a_wd, a_rdata;
    logic        a_busy;
    logic [15:0] a_hit, a_miss;

    logic        b_rd, b_wr;
    logic [9:0]  b_addr;
    logic [15:0] b_wd, b_rdata;
    logic        b_busy;
    logic [1:0]  b_hit, b_miss;

    dcache_wb_param_if #(.MADDR_W(7), .BLK_W(16)) a_mem ();
    dcache_wb_param_if #(.MADDR_W(8), .BLK_W(64)) b_mem ();

    dcache_wb_param dut_a (
        .CLK        (CLK),
        .reset      (reset),
        .cpu_read   (a_rd),
        .cpu_write  (a_wr),
        .cpu_addr   (a_addr),
        .cpu_wdata  (a_wd),
        .cpu_rdata  (a_rdata),
        .busy       (a_busy),
        .mem        (a_mem),
        .hit_count  (a_hit),
        .miss_count (a_miss)
    );

    dcache_wb_param #(
        .ADDR_W (10),
        .DATA_W (16),
        .LINES  (16),
        .WPB    (4),
        .CNT_W  (2)
    ) dut_b (
        .CLK        (CLK),
        .reset      (reset),
        .cpu_read   (b_rd),
        .cpu_write  (b_wr),
        .cpu_addr   (b_addr),
        .cpu_wdata  (b_wd),
        .cpu_rdata  (b_rdata),
        .busy       (b_busy),
        .mem        (b_mem),
        .hit_count  (b_hit),
        .miss_count (b_miss)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: CPU-visible bytes, memory contents, and which block
    // each line holds (direct mapping: line = block mod 8).
    logic [7:0]  flat   [256];
    logic [15:0] mstore [128];
    bit          rv     [8];
    bit          rdy    [8];
    logic [6:0]  rblk   [8];
    int          e_hit, e_miss;

    task automatic ack_a(input int lat, input logic [15:0] d);
        repeat (lat) @(negedge CLK);
        a_mem.mem_rdata = d;
        a_mem.mem_ack   = 1'b1;
        @(posedge CLK);
        #1 a_mem.mem_ack = 1'b0;
    endtask

    task automatic a_access(input bit wr, input logic [7:0] addr,
                            input logic [7:0] wd);
        logic [6:0] blk;
        logic [2:0] idx;
        bit ph, pd, done, wb_seen;
        int n;
        blk = addr[7:1];
        idx = blk[2:0];
        ph  = rv[idx] && rblk[idx] == blk;
        pd  = rv[idx] && rdy[idx] && !ph;
        a_rd = !wr; a_wr = wr; a_addr = addr; a_wd = wd;
        @(negedge CLK);
        chk("r_busy", 64'(a_busy), 64'(!ph));
        n = 0; done = 0; wb_seen = 0;
        while (!done && n < 100) begin
            if (!a_busy) begin
                if (!wr) chk("r_rdata", 64'(a_rdata), 64'(flat[addr]));
                done = 1;
            end else if (a_mem.mem_write) begin
                wb_seen = 1;
                chk("r_wb_addr", 64'(a_mem.mem_addr), 64'(rblk[idx]));
                chk("r_wb_data", 64'(a_mem.mem_wdata),
                    64'({flat[{rblk[idx], 1'b1}], flat[{rblk[idx], 1'b0}]}));
                mstore[a_mem.mem_addr] = a_mem.mem_wdata;
                ack_a($urandom_range(0, 3), 16'h0);
            end else if (a_mem.mem_read) begin
                chk("r_fill_addr", 64'(a_mem.mem_addr), 64'(blk));
                ack_a($urandom_range(0, 3), mstore[blk]);
            end
            if (!done) @(negedge CLK);
            n++;
        end
        if (!done) chk("r_timeout", 64'(a_busy), 64'(0));
        chk("r_wb_seen", 64'(wb_seen), 64'(pd));
        @(posedge CLK);
        #1 a_rd = 0; a_wr = 0;
        if (wr) flat[addr] = wd;
        if (ph) begin
            e_hit++;
            if (wr) rdy[idx] = 1;
        end else begin
            e_miss++;
            rv[idx] = 1; rblk[idx] = blk; rdy[idx] = wr;
        end
        @(negedge CLK);
        chk("r_hits", 64'(a_hit), 64'(e_hit));
        chk("r_misses", 64'(a_miss), 64'(e_miss));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
        @(negedge CLK);
        chk("rst_busy", 64'(a_busy), 64'(0));
        chk("rst_mrd", 64'(a_mem.mem_read), 64'(0));
        chk("rst_mwr", 64'(a_mem.mem_write), 64'(0));
        chk("rst_rdata", 64'(a_rdata), 64'(0));
        chk("rst_hit", 64'(a_hit), 64'(0));
        chk("rst_miss", 64'(a_miss), 64'(0));
        @(posedge CLK);
        #1 reset = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rd = 0; a_wr = 0; a_addr = '0; a_wd = '0;
        b_rd = 0; b_wr = 0; b_addr = '0; b_wd = '0;
        a_mem.mem_ack = 0; a_mem.mem_rdata = '0;
        b_mem.mem_ack = 0; b_mem.mem_rdata = '0;
        for (int b = 0; b < 128; b++) begin
            mstore[b] = 16'($urandom);
            flat[2*b]   = mstore[b][7:0];
            flat[2*b+1] = mstore[b][15:8];
        end
        for (int i = 0; i < 8; i++) begin
            rv[i] = 0; rdy[i] = 0; rblk[i] = '0;
        end
        e_hit = 0; e_miss = 0;
        do_reset();

        for (int k = 0; k < 300; k++) begin
            logic [7:0] ad;
            ad = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : 8'($urandom_range(0, 47));
            a_access(1'($urandom), ad, 8'($urandom));
        end

        // Directed scenarios on the default build.
        do_reset();
        a_rd = 1; a_addr = 8'h23;
        @(negedge CLK);
        chk("d_miss_busy", 64'(a_busy), 64'(1));
        chk("d_idle_nomem", 64'(a_mem.mem_read), 64'(0));
        @(negedge CLK);
        chk("d_fill_req", 64'(a_mem.mem_read), 64'(1));
        chk("d_fill_addr", 64'(a_mem.mem_addr), 64'(8'h11));
        chk("d_fill_nowr", 64'(a_mem.mem_write), 64'(0));
        repeat (4) @(negedge CLK);
        chk("d_fill_hold", 64'(a_mem.mem_read), 64'(1));
        ack_a(0, 16'hBEEF);
        @(negedge CLK);
        chk("d_retry_busy", 64'(a_busy), 64'(0));
        chk("d_retry_rdata", 64'(a_rdata), 64'(8'hBE));
        chk("d_miss1", 64'(a_miss), 64'(1));
        chk("d_hit0", 64'(a_hit), 64'(0));
        @(posedge CLK);
        #1 a_rd = 0; a_wr = 1; a_addr = 8'h22; a_wd = 8'h07;
        @(negedge CLK);
        chk("d_wr_busy", 64'(a_busy), 64'(0));
        chk("d_wr_nomem", 64'({a_mem.mem_read, a_mem.mem_write}), 64'(0));
        @(posedge CLK);
        #1 a_wr = 0; a_rd = 1;
        @(negedge CLK);
        chk("d_rd_after_wr", 64'(a_rdata), 64'(8'h07));
        @(posedge CLK);
        #1 a_rd = 0;
        @(negedge CLK);
        chk("d_hit2", 64'(a_hit), 64'(2));

        @(posedge CLK);
        #1 a_rd = 1; a_addr = 8'hA2;
        @(negedge CLK);
        chk("d_dm_busy", 64'(a_busy), 64'(1));
        @(negedge CLK);
        chk("d_wb_req", 64'(a_mem.mem_write), 64'(1));
        chk("d_wb_nord", 64'(a_mem.mem_read), 64'(0));
        chk("d_wb_addr", 64'(a_mem.mem_addr), 64'(8'h11));
        chk("d_wb_data", 64'(a_mem.mem_wdata), 64'(16'hBE07));
        @(negedge CLK);
        chk("d_wb_hold", 64'(a_mem.mem_wdata), 64'(16'hBE07));
        ack_a(0, 16'h0);
        @(negedge CLK);
        chk("d_al_req", 64'({a_mem.mem_read, a_mem.mem_write}), 64'(2'b10));
        chk("d_al_addr", 64'(a_mem.mem_addr), 64'(8'h51));
        ack_a(1, 16'h1234);
        @(negedge CLK);
        chk("d_dm_rdata", 64'(a_rdata), 64'(8'h34));
        chk("d_miss2", 64'(a_miss), 64'(2));
        @(posedge CLK);
        #1 a_rd = 0;

        // Reset while a fill is outstanding.
        @(posedge CLK);
        #1 a_rd = 1; a_addr = 8'h23;
        @(negedge CLK);
        @(negedge CLK);
        chk("d_pre_rst_rd", 64'(a_mem.mem_read), 64'(1));
        #2 reset = 1; a_rd = 0;
        #1;
        chk("d_rst_mrd", 64'(a_mem.mem_read), 64'(0));
        chk("d_rst_busy", 64'(a_busy), 64'(0));
        @(posedge CLK);
        #1 reset = 0; a_rd = 1; a_addr = 8'hA2;
        @(negedge CLK);
        chk("d_post_rst_miss", 64'(a_busy), 64'(1));
        @(negedge CLK);
        chk("d_post_rst_addr", 64'(a_mem.mem_addr), 64'(8'h51));
        ack_a(0, 16'h1234);
        @(negedge CLK);
        chk("d_post_rst_rd", 64'(a_rdata), 64'(8'h34));
        chk("d_post_rst_cnt", 64'(a_miss), 64'(1));
        @(posedge CLK);
        #1 a_rd = 1; a_wr = 1; a_addr = 8'h22; a_wd = 8'h55;

        // Both strobes high, plus a stray ack: nothing may happen.
        @(negedge CLK);
        chk("d_both_busy", 64'(a_busy), 64'(0));
        chk("d_both_nomem", 64'({a_mem.mem_read, a_mem.mem_write}), 64'(0));
        chk("d_both_rdata", 64'(a_rdata), 64'(0));
        ack_a(0, 16'hFFFF);
        @(negedge CLK);
        chk("d_ack_idle", 64'({a_busy, a_mem.mem_read}), 64'(0));
        chk("d_both_cnt", 64'({a_hit, a_miss}), 64'({16'd0, 16'd1}));
        @(posedge CLK);
        #1 a_wr = 0; a_addr = 8'hA2;
        @(negedge CLK);
        chk("d_both_keep", 64'(a_rdata), 64'(8'h34));
        chk("d_both_hit", 64'(a_busy), 64'(0));
        @(posedge CLK);
        #1 a_rd = 0;
        @(negedge CLK);
        chk("d_hit1", 64'(a_hit), 64'(1));

        // Wider build: 16 lines, 4 words/block, 2-bit counters.
        @(posedge CLK);
        #1 b_rd = 1; b_addr = 10'h0F7;
        @(negedge CLK);
        chk("b_miss_busy", 64'(b_busy), 64'(1));
        @(negedge CLK);
        chk("b_fill_req", 64'(b_mem.mem_read), 64'(1));
        chk("b_fill_addr", 64'(b_mem.mem_addr), 64'(8'h3D));
        b_mem.mem_rdata = 64'h4444_3333_2222_1111;
        b_mem.mem_ack = 1;
        @(posedge CLK);
        #1 b_mem.mem_ack = 0;
        @(negedge CLK);
        chk("b_rdata", 64'(b_rdata), 64'(16'h4444));
        chk("b_miss1", 64'(b_miss), 64'(1));
        chk("b_hit0", 64'(b_hit), 64'(0));
        repeat (3) @(negedge CLK);
        chk("b_hit2", 64'(b_hit), 64'(2));
        repeat (3) @(negedge CLK);
        chk("b_hit_sat", 64'(b_hit), 64'(3));
        @(posedge CLK);
        #1 b_rd = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
